// File: rtl/reflet_rom_pkg.sv
// Shared definitions for the ROM prefetcher: controller states, header
// magic ("ASRM") and the default first code address.
package reflet_rom_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_RUN  = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  localparam logic [7:0] CODE_BASE_DEFAULT = 8'd4;

  localparam logic [7:0] MAGIC_0 = 8'h41;
  localparam logic [7:0] MAGIC_1 = 8'h53;
  localparam logic [7:0] MAGIC_2 = 8'h52;
  localparam logic [7:0] MAGIC_3 = 8'h4D;

  function automatic logic [7:0] magic_byte(input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = MAGIC_0;
      2'd1:    b = MAGIC_1;
      2'd2:    b = MAGIC_2;
      default: b = MAGIC_3;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Prefetch buffer: 16-bit entries (pc in the upper byte, data in the lower),
// power-of-two depth, flush takes priority over push and pop.
module byte_fifo #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic [15:0]   push_data,
  input  logic          pop,
  output logic [15:0]   head_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/rom_prefetch.sv
// Fetches bytes from a registered one-cycle-latency ROM, optionally checks
// the "ASRM" header, and streams code bytes with their pc over valid/ready.
module rom_prefetch
  import reflet_rom_pkg::*;
#(
  parameter int         FIFO_DEPTH   = 4,
  parameter bit         CHECK_HEADER = 1'b1,
  parameter logic [7:0] CODE_BASE    = CODE_BASE_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       jump,
  input  logic [7:0] jump_addr,
  output logic [7:0] rom_addr,
  output logic       rom_en,
  input  logic [7:0] rom_data,
  output logic [7:0] instr,
  output logic [7:0] instr_pc,
  output logic       instr_valid,
  input  logic       instr_ready,
  output logic       header_ok,
  output logic       header_err,
  output logic       busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t        state, state_d;
  logic [7:0]    rom_addr_d;
  logic          rom_en_d;
  logic          rd_pend, rd_pend_d;
  logic [7:0]    rd_addr, rd_addr_d;
  logic          header_ok_d;
  logic          fifo_flush, fifo_push, fifo_pop;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [15:0]   fifo_head;
  int            occ_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      rom_addr  <= 8'h00;
      rom_en    <= 1'b0;
      rd_pend   <= 1'b0;
      rd_addr   <= 8'h00;
      header_ok <= 1'b0;
    end else begin
      state     <= state_d;
      rom_addr  <= rom_addr_d;
      rom_en    <= rom_en_d;
      rd_pend   <= rd_pend_d;
      rd_addr   <= rd_addr_d;
      header_ok <= header_ok_d;
    end
  end

  // rd_pend/rd_addr track the read issued last cycle, whose data is on rom_data now.
  always_comb begin
    state_d     = state;
    rom_addr_d  = rom_addr;
    rom_en_d    = 1'b0;
    rd_pend_d   = rom_en;
    rd_addr_d   = rom_addr;
    header_ok_d = header_ok;
    fifo_flush  = 1'b0;
    fifo_push   = 1'b0;
    fifo_pop    = instr_valid && instr_ready;
    occ_next    = 0;

    case (state)
      ST_IDLE, ST_ERR: begin
        if (start) begin
          fifo_flush  = 1'b1;
          header_ok_d = 1'b0;
          rd_pend_d   = 1'b0;
          rom_en_d    = 1'b1;
          if (CHECK_HEADER) begin
            state_d    = ST_HDR;
            rom_addr_d = 8'h00;
          end else begin
            state_d    = ST_RUN;
            rom_addr_d = CODE_BASE;
          end
        end
      end

      ST_HDR: begin
        if (rd_pend && (rom_data != magic_byte(rd_addr[1:0]))) begin
          state_d   = ST_ERR;
          rd_pend_d = 1'b0;
        end else if (rd_pend && (rd_addr[1:0] == 2'd3)) begin
          state_d     = ST_RUN;
          rom_addr_d  = CODE_BASE;
          rom_en_d    = 1'b1;
          rd_pend_d   = 1'b0;
          header_ok_d = 1'b1;
        end else begin
          rom_en_d = 1'b1;
          if (rom_addr[1:0] != 2'd3) rom_addr_d = rom_addr + 8'd1;
        end
      end

      ST_RUN: begin
        if (jump) begin
          fifo_flush = 1'b1;
          rom_addr_d = jump_addr;
          rom_en_d   = 1'b1;
          rd_pend_d  = 1'b0;
        end else begin
          // Issue next cycle only if buffered plus in-flight bytes still leave a free slot.
          fifo_push = rd_pend && (!fifo_full || fifo_pop);
          occ_next  = int'(fifo_count) + int'(fifo_push) - int'(fifo_pop) + int'(rom_en);
          rom_en_d  = (occ_next < FIFO_DEPTH);
          if (rom_en) rom_addr_d = rom_addr + 8'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_data ({rd_addr, rom_data}),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign instr_valid = !fifo_empty;
  assign instr       = fifo_empty ? 8'h00 : fifo_head[7:0];
  assign instr_pc    = fifo_empty ? 8'h00 : fifo_head[15:8];
  assign header_err  = (state == ST_ERR);
  assign busy        = (state == ST_HDR) || (state == ST_RUN);

endmodule

// File: tb/tb_rom_prefetch.sv
// Self-checking bench for rom_prefetch: directed timing checks plus a random
// ready/jump phase scored against an ideal pc-ordered byte stream from the ROM.
module tb_rom_prefetch;

  localparam int         FIFO_DEPTH = 4;
  localparam logic [7:0] CODE_BASE  = 8'd4;

  logic       clk;
  logic       reset;
  logic       start;
  logic       jump;
  logic [7:0] jump_addr;
  logic [7:0] rom_addr;
  logic       rom_en;
  logic [7:0] rom_data;
  logic [7:0] instr;
  logic [7:0] instr_pc;
  logic       instr_valid;
  logic       instr_ready;
  logic       header_ok;
  logic       header_err;
  logic       busy;

  logic [7:0] rom_mem [256];
  logic [7:0] nom_bytes [4];

  int checks    = 0;
  int errors    = 0;
  int delivered = 0;

  logic [7:0] exp_pc     = 8'h00;
  logic       chk_stall  = 1'b0;
  logic       chk_jump   = 1'b0;
  logic [7:0] held_pc    = 8'h00;
  logic [7:0] held_instr = 8'h00;

  rom_prefetch #(
    .FIFO_DEPTH   (FIFO_DEPTH),
    .CHECK_HEADER (1'b1),
    .CODE_BASE    (CODE_BASE)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .jump        (jump),
    .jump_addr   (jump_addr),
    .rom_addr    (rom_addr),
    .rom_en      (rom_en),
    .rom_data    (rom_data),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .header_ok   (header_ok),
    .header_err  (header_err),
    .busy        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Registered ROM with one cycle of latency, zero when not enabled.
  always @(posedge clk) rom_data <= rom_en ? rom_mem[rom_addr] : 8'h00;

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive inputs for the current cycle, then move to the middle of the next one.
  task automatic applyStimulus(input logic st, input logic jmp, input logic [7:0] ja);
    start     = st;
    jump      = jmp;
    jump_addr = ja;
    @(negedge clk);
    start = 1'b0;
    jump  = 1'b0;
  endtask

  task automatic waitValid(input string tag);
    int n = 0;
    while (!instr_valid && n < 20) begin
      applyStimulus(1'b0, 1'b0, 8'h00);
      n++;
    end
    checkOutput(tag, 16'(instr_valid), 16'd1);
  endtask

  task automatic doReset();
    reset = 1'b1;
    start = 1'b0;
    jump  = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic runNominal();
    instr_ready = 1'b1;
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("c1_rom_addr", 16'(rom_addr), 16'h00);
    checkOutput("c1_rom_en", 16'(rom_en), 16'd1);
    checkOutput("c1_busy", 16'(busy), 16'd1);
    checkOutput("c1_header_ok", 16'(header_ok), 16'd0);
    repeat (5) applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("c6_header_ok", 16'(header_ok), 16'd1);
    checkOutput("c6_rom_addr", 16'(rom_addr), 16'(CODE_BASE));
    checkOutput("c6_rom_en", 16'(rom_en), 16'd1);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("c7_valid", 16'(instr_valid), 16'd0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 8'h00);
      checkOutput("nom_valid", 16'(instr_valid), 16'd1);
      checkOutput("nom_pc", 16'(instr_pc), 16'(int'(CODE_BASE) + i));
      checkOutput("nom_data", 16'(instr), 16'(nom_bytes[i]));
    end
  endtask

  // Stream scoreboard: every accepted byte must be the next pc with its ROM value.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        chk_stall = 1'b0;
        chk_jump  = 1'b0;
      end else begin
        if (chk_jump) begin
          checkOutput("jump_flush_valid", 16'(instr_valid), 16'd0);
        end else if (chk_stall) begin
          checkOutput("stall_valid", 16'(instr_valid), 16'd1);
          checkOutput("stall_pc", 16'(instr_pc), 16'(held_pc));
          checkOutput("stall_data", 16'(instr), 16'(held_instr));
        end
        if (start && !busy) exp_pc = CODE_BASE;
        if (instr_valid && instr_ready) begin
          checkOutput("stream_pc", 16'(instr_pc), 16'(exp_pc));
          checkOutput("stream_data", 16'(instr), 16'(rom_mem[exp_pc]));
          exp_pc = exp_pc + 8'd1;
          delivered++;
        end
        chk_jump = jump && busy && header_ok;
        if (chk_jump) exp_pc = jump_addr;
        chk_stall  = instr_valid && !instr_ready && !chk_jump;
        held_pc    = instr_pc;
        held_instr = instr;
      end
    end
  end

  initial begin
    logic seen_valid;
    for (int i = 0; i < 256; i++) rom_mem[i] = 8'($urandom);
    rom_mem[0] = 8'h41; rom_mem[1] = 8'h53; rom_mem[2] = 8'h52; rom_mem[3] = 8'h4D;
    rom_mem[4] = 8'h14; rom_mem[5] = 8'h3C; rom_mem[6] = 8'h10; rom_mem[7] = 8'h3B;
    rom_mem[8] = 8'h10;
    rom_mem[8'hFF] = 8'h00;
    nom_bytes[0] = 8'h14; nom_bytes[1] = 8'h3C; nom_bytes[2] = 8'h10; nom_bytes[3] = 8'h3B;

    reset = 1'b1; start = 1'b0; jump = 1'b0; jump_addr = 8'h00; instr_ready = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_rom_addr", 16'(rom_addr), 16'h00);
    checkOutput("rst_rom_en", 16'(rom_en), 16'd0);
    checkOutput("rst_valid", 16'(instr_valid), 16'd0);
    checkOutput("rst_header_ok", 16'(header_ok), 16'd0);
    checkOutput("rst_header_err", 16'(header_err), 16'd0);
    checkOutput("rst_busy", 16'(busy), 16'd0);
    reset = 1'b0;
    repeat (2) applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("idle_rom_en", 16'(rom_en), 16'd0);

    $display("[TB] nominal header + stream");
    runNominal();

    $display("[TB] backpressure");
    doReset();
    instr_ready = 1'b0;
    applyStimulus(1'b1, 1'b0, 8'h00);
    repeat (15) applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("bp_valid", 16'(instr_valid), 16'd1);
    checkOutput("bp_pc", 16'(instr_pc), 16'(CODE_BASE));
    checkOutput("bp_data", 16'(instr), 16'h14);
    checkOutput("bp_rom_stalled", 16'(rom_en), 16'd0);
    instr_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checkOutput("bp_no_gap", 16'(instr_valid), 16'd1);
      if (i == 4) begin
        checkOutput("bp_pc8", 16'(instr_pc), 16'h08);
        checkOutput("bp_pc8_data", 16'(instr), 16'h10);
      end
      applyStimulus(1'b0, 1'b0, 8'h00);
    end

    $display("[TB] jump with handshake");
    checkOutput("jmp_pre_valid", 16'(instr_valid), 16'd1);
    applyStimulus(1'b0, 1'b1, 8'h2B);
    checkOutput("jmp_valid_low", 16'(instr_valid), 16'd0);
    checkOutput("jmp_rom_addr", 16'(rom_addr), 16'h2B);
    waitValid("jmp_wait");
    checkOutput("jmp_pc", 16'(instr_pc), 16'h2B);
    checkOutput("jmp_data", 16'(instr), 16'(rom_mem[8'h2B]));

    $display("[TB] address wrap");
    applyStimulus(1'b0, 1'b1, 8'hFF);
    waitValid("wrap_wait");
    checkOutput("wrap_pc_ff", 16'(instr_pc), 16'hFF);
    checkOutput("wrap_data_ff", 16'(instr), 16'h00);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("wrap_valid_00", 16'(instr_valid), 16'd1);
    checkOutput("wrap_pc_00", 16'(instr_pc), 16'h00);
    checkOutput("wrap_data_00", 16'(instr), 16'h41);

    $display("[TB] random ready/jump/start");
    for (int i = 0; i < 400; i++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      applyStimulus(($urandom_range(0, 29) == 0), ($urandom_range(0, 19) == 0), 8'($urandom));
    end
    instr_ready = 1'b1;
    repeat (10) applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("rand_busy", 16'(busy), 16'd1);
    checkOutput("rand_progress", 16'(delivered > 100), 16'd1);

    $display("[TB] bad header");
    rom_mem[2] = 8'h00;
    doReset();
    applyStimulus(1'b1, 1'b0, 8'h00);
    repeat (5) applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("bad_header_err", 16'(header_err), 16'd1);
    checkOutput("bad_rom_en", 16'(rom_en), 16'd0);
    checkOutput("bad_busy", 16'(busy), 16'd0);
    checkOutput("bad_header_ok", 16'(header_ok), 16'd0);
    seen_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      seen_valid = seen_valid | instr_valid;
      applyStimulus(1'b0, 1'b1, 8'h10);
    end
    checkOutput("bad_never_valid", 16'(seen_valid), 16'd0);
    checkOutput("bad_still_err", 16'(header_err), 16'd1);
    rom_mem[2] = 8'h52;

    $display("[TB] reset mid-run");
    doReset();
    instr_ready = 1'b0;
    applyStimulus(1'b1, 1'b0, 8'h00);
    repeat (9) applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("pre_rst_valid", 16'(instr_valid), 16'd1);
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_rom_addr", 16'(rom_addr), 16'h00);
    checkOutput("mid_rst_rom_en", 16'(rom_en), 16'd0);
    checkOutput("mid_rst_instr", 16'(instr), 16'h00);
    checkOutput("mid_rst_pc", 16'(instr_pc), 16'h00);
    checkOutput("mid_rst_valid", 16'(instr_valid), 16'd0);
    checkOutput("mid_rst_header_ok", 16'(header_ok), 16'd0);
    checkOutput("mid_rst_header_err", 16'(header_err), 16'd0);
    checkOutput("mid_rst_busy", 16'(busy), 16'd0);
    @(negedge clk);
    reset = 1'b0;
    instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 8'h00);
      checkOutput("post_rst_rom_en", 16'(rom_en), 16'd0);
      checkOutput("post_rst_valid", 16'(instr_valid), 16'd0);
    end
    runNominal();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
